// File: rtl/conv_pkg.sv
// Shared types for the conv-layer pixel path: sample width, default frame size,
// streamer FSM states and the per-beat pixel record.
package conv_pkg;

   localparam int DATA_WIDTH   = 8;
   localparam int FRAME_WIDTH  = 224;
   localparam int FRAME_HEIGHT = 224;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOADW,
      ST_SETTLE,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] r;
      logic [DATA_WIDTH-1:0] g;
      logic [DATA_WIDTH-1:0] b;
      logic                  sof;
      logic                  eol;
   } rgb_pix_t;

endpackage

// File: rtl/rgb_skid_buf.sv
// One-entry skid buffer on rgb_pix_t: input passes straight through, and is parked when the sink stalls.
// Latency 0 (pass-through); backpressure: in_rdy means a beat presented next cycle has a slot.
module rgb_skid_buf
   import conv_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     in_vld,
   output logic     in_rdy,
   input  rgb_pix_t in_dat,
   output logic     out_vld,
   input  logic     out_rdy,
   output rgb_pix_t out_dat
);

   logic     full;
   rgb_pix_t hold_dat;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full     <= 1'b0;
         hold_dat <= '0;
      end else if (full) begin
         if (out_rdy)
            full <= 1'b0;
      end else if (in_vld && !out_rdy) begin
         full     <= 1'b1;
         hold_dat <= in_dat;
      end
   end

   // Idle outputs are forced to zero so RAM bus noise never reaches the sink.
   assign out_vld = full | in_vld;
   assign out_dat = full ? hold_dat : (in_vld ? in_dat : '0);
   assign in_rdy  = !full | out_rdy;

endmodule

// File: rtl/rgb_frame_streamer.sv
// Streams one HEIGHT x WIDTH planar RGB frame to the conv layer after a load_weight pulse and settle gap.
// Latency: first beat 2 cycles after SETTLE; backpressure via pixel_ready, one in-flight read absorbed by a skid.
module rgb_frame_streamer
   import conv_pkg::*;
#(
   parameter int WIDTH         = FRAME_WIDTH,
   parameter int HEIGHT        = FRAME_HEIGHT,
   parameter int SETTLE_CYCLES = 5,
   parameter int ADDR_W        = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  mem_rd_en,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata_r,
   input  logic [DATA_WIDTH-1:0] mem_rdata_g,
   input  logic [DATA_WIDTH-1:0] mem_rdata_b,
   output logic                  load_weight,
   output logic [DATA_WIDTH-1:0] pixel_out_r,
   output logic [DATA_WIDTH-1:0] pixel_out_g,
   output logic [DATA_WIDTH-1:0] pixel_out_b,
   output logic                  pixel_valid,
   input  logic                  pixel_ready,
   output logic                  sof,
   output logic                  eol,
   output logic                  busy,
   output logic                  done
);

   localparam int CW = $clog2(WIDTH);
   localparam int RW = $clog2(HEIGHT);
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   state_t          state, state_nxt;
   logic [CW-1:0]   col;
   logic [RW-1:0]   row;
   logic [ADDR_W-1:0] addr;
   logic [SW-1:0]   settle_cnt;
   logic            rd_pend, rd_sof, rd_eol;
   logic            last_col, last_pix, skid_in_rdy;
   rgb_pix_t        ram_pix, out_pix;

   assign last_col = (col == CW'(WIDTH - 1));
   assign last_pix = last_col && (row == RW'(HEIGHT - 1));

   always_comb begin
      state_nxt   = state;
      mem_rd_en   = 1'b0;
      load_weight = 1'b0;
      done        = 1'b0;
      busy        = (state != ST_IDLE);
      case (state)
         ST_IDLE:   if (start) state_nxt = ST_LOADW;
         ST_LOADW: begin
            load_weight = 1'b1;
            state_nxt   = (SETTLE_CYCLES == 0) ? ST_STREAM : ST_SETTLE;
         end
         ST_SETTLE: if (int'(settle_cnt) == SETTLE_CYCLES - 1) state_nxt = ST_STREAM;
         ST_STREAM: begin
            // Only read when the returning beat is guaranteed a place next cycle.
            mem_rd_en = skid_in_rdy && (pixel_ready || !pixel_valid);
            if (mem_rd_en && last_pix) state_nxt = ST_DRAIN;
         end
         ST_DRAIN:  if (!pixel_valid || pixel_ready) state_nxt = ST_DONE;
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col        <= '0;
         row        <= '0;
         addr       <= '0;
         settle_cnt <= '0;
         rd_pend    <= 1'b0;
         rd_sof     <= 1'b0;
         rd_eol     <= 1'b0;
      end else begin
         rd_pend <= mem_rd_en;
         if (mem_rd_en) begin
            rd_sof <= (addr == '0);
            rd_eol <= last_col;
            addr   <= addr + 1'b1;
            if (last_col) begin
               col <= '0;
               row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
         if (state == ST_SETTLE) settle_cnt <= settle_cnt + 1'b1;
         else                    settle_cnt <= '0;
         if (state == ST_DONE) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
         end
      end
   end

   // Flags are captured at read issue so they line up with the RAM return.
   assign ram_pix = '{r: mem_rdata_r, g: mem_rdata_g, b: mem_rdata_b, sof: rd_sof, eol: rd_eol};

   rgb_skid_buf u_skid (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (rd_pend),
      .in_rdy  (skid_in_rdy),
      .in_dat  (ram_pix),
      .out_vld (pixel_valid),
      .out_rdy (pixel_ready),
      .out_dat (out_pix)
   );

   assign mem_addr    = addr;
   assign pixel_out_r = out_pix.r;
   assign pixel_out_g = out_pix.g;
   assign pixel_out_b = out_pix.b;
   assign sof         = out_pix.sof;
   assign eol         = out_pix.eol;

endmodule

// File: tb/tb_rgb_frame_streamer.sv
// Directed bench: 4x3 frame cycle table plus backpressure, skid, reset, start-abuse and full-size runs.
module tb_rgb_frame_streamer;
   import conv_pkg::*;

   logic clk, rst, start, pixel_ready;
   logic mem_rd_en, load_weight, pixel_valid, sof, eol, busy, done;
   logic [7:0] mem_addr, mem_rdata_r, mem_rdata_g, mem_rdata_b;
   logic [7:0] pixel_out_r, pixel_out_g, pixel_out_b;

   logic start2, ready2, rd2, lw2, pv2, sof2, eol2, busy2, done2;
   logic [15:0] addr2;
   logic [7:0] r2, g2, b2, or2, og2, ob2;

   int n_chk = 0, n_fail = 0;
   int lw_cnt = 0, done_cnt = 0;
   rgb_pix_t beats[$];
   logic stall_prev = 1'b0;
   logic [25:0] stall_dat;

   logic [15:0] idx2 = '0;
   int err2 = 0, eolc2 = 0, sofc2 = 0, lwc2 = 0, dc2 = 0, beats2 = 0;

   typedef struct {
      logic rdy, lw, rd, vld;
      logic [7:0] dat;
      logic sf, el, dn, bsy;
   } vec_t;
   vec_t tbl[21];

   rgb_frame_streamer #(.WIDTH(4), .HEIGHT(3), .SETTLE_CYCLES(5), .ADDR_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
      .mem_rdata_r(mem_rdata_r), .mem_rdata_g(mem_rdata_g), .mem_rdata_b(mem_rdata_b),
      .load_weight(load_weight), .pixel_out_r(pixel_out_r), .pixel_out_g(pixel_out_g),
      .pixel_out_b(pixel_out_b), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
      .sof(sof), .eol(eol), .busy(busy), .done(done));

   rgb_frame_streamer dut_full (
      .clk(clk), .rst(rst), .start(start2), .mem_rd_en(rd2), .mem_addr(addr2),
      .mem_rdata_r(r2), .mem_rdata_g(g2), .mem_rdata_b(b2),
      .load_weight(lw2), .pixel_out_r(or2), .pixel_out_g(og2),
      .pixel_out_b(ob2), .pixel_valid(pv2), .pixel_ready(ready2),
      .sof(sof2), .eol(eol2), .busy(busy2), .done(done2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Frame RAM models: one-cycle read latency, contents derived from the address.
   always @(posedge clk) if (mem_rd_en) begin
      mem_rdata_r <= mem_addr;
      mem_rdata_g <= mem_addr + 8'd100;
      mem_rdata_b <= mem_addr ^ 8'hA5;
   end
   always @(posedge clk) if (rd2) begin
      r2 <= addr2[7:0];
      g2 <= addr2[15:8];
      b2 <= addr2[7:0] ^ addr2[15:8];
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (stall_prev)
            chk("stall_hold", {pixel_valid, pixel_out_r, pixel_out_g, pixel_out_b, sof, eol},
                {1'b1, stall_dat});
         if (pixel_valid && pixel_ready)
            beats.push_back('{r: pixel_out_r, g: pixel_out_g, b: pixel_out_b, sof: sof, eol: eol});
         if (load_weight) lw_cnt++;
         if (done) done_cnt++;
         stall_prev = pixel_valid && !pixel_ready;
         stall_dat  = {pixel_out_r, pixel_out_g, pixel_out_b, sof, eol};
      end else begin
         stall_prev = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         if (pv2) begin
            if ({or2, og2, ob2} !== {idx2[7:0], idx2[15:8], idx2[7:0] ^ idx2[15:8]} ||
                sof2 !== (idx2 == 16'd0) || eol2 !== (idx2 % 16'd224 == 16'd223))
               err2++;
            if (eol2) eolc2++;
            if (sof2) sofc2++;
            idx2++;
            beats2++;
         end
         if (lw2) lwc2++;
         if (done2) dc2++;
      end
   end

   task automatic check_frames(input string nm, input int nfr);
      rgb_pix_t e;
      int idx;
      chk({nm, "_beats"}, beats.size(), 12 * nfr);
      for (int i = 0; i < beats.size() && i < 12 * nfr; i++) begin
         idx   = i % 12;
         e.r   = 8'(idx);
         e.g   = 8'(idx + 100);
         e.b   = 8'(idx) ^ 8'hA5;
         e.sof = (idx == 0);
         e.eol = (idx % 4 == 3);
         chk($sformatf("%s_beat%0d", nm, i), beats[i], e);
      end
      beats.delete();
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic run_until_done(input string nm, input bit rnd, input int maxc);
      bit seen = 1'b0;
      for (int c = 0; c < maxc && !seen; c++) begin
         @(posedge clk); #1;
         pixel_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk({nm, "_done_seen"}, seen, 1);
      @(posedge clk); #1 pixel_ready = 1'b1;
   endtask

   task automatic wait_beat(input string nm, input logic [7:0] val);
      bit found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         if (pixel_valid && pixel_ready && pixel_out_r == val) found = 1'b1;
      end
      chk({nm, "_beat_seen"}, found, 1);
   endtask

   initial begin
      int lw0, d0, nd, cyc;
      bit chk_idle;
      // Cycle k counts from the cycle after start is sampled.
      tbl[0]  = '{1, 1, 0, 0, 8'd0,  0, 0, 0, 1};
      tbl[1]  = '{1, 0, 0, 0, 8'd0,  0, 0, 0, 1};
      tbl[2]  = '{1, 0, 0, 0, 8'd0,  0, 0, 0, 1};
      tbl[3]  = '{1, 0, 0, 0, 8'd0,  0, 0, 0, 1};
      tbl[4]  = '{1, 0, 0, 0, 8'd0,  0, 0, 0, 1};
      tbl[5]  = '{1, 0, 0, 0, 8'd0,  0, 0, 0, 1};
      tbl[6]  = '{1, 0, 1, 0, 8'd0,  0, 0, 0, 1};
      tbl[7]  = '{1, 0, 1, 1, 8'd0,  1, 0, 0, 1};
      tbl[8]  = '{1, 0, 1, 1, 8'd1,  0, 0, 0, 1};
      tbl[9]  = '{1, 0, 1, 1, 8'd2,  0, 0, 0, 1};
      tbl[10] = '{1, 0, 1, 1, 8'd3,  0, 1, 0, 1};
      tbl[11] = '{1, 0, 1, 1, 8'd4,  0, 0, 0, 1};
      tbl[12] = '{1, 0, 1, 1, 8'd5,  0, 0, 0, 1};
      tbl[13] = '{1, 0, 1, 1, 8'd6,  0, 0, 0, 1};
      tbl[14] = '{1, 0, 1, 1, 8'd7,  0, 1, 0, 1};
      tbl[15] = '{1, 0, 1, 1, 8'd8,  0, 0, 0, 1};
      tbl[16] = '{1, 0, 1, 1, 8'd9,  0, 0, 0, 1};
      tbl[17] = '{1, 0, 1, 1, 8'd10, 0, 0, 0, 1};
      tbl[18] = '{1, 0, 0, 1, 8'd11, 0, 1, 0, 1};
      tbl[19] = '{1, 0, 0, 0, 8'd0,  0, 0, 1, 1};
      tbl[20] = '{1, 0, 0, 0, 8'd0,  0, 0, 0, 0};

      rst = 1'b0; start = 1'b0; start2 = 1'b0; pixel_ready = 1'b1; ready2 = 1'b1;
      #2;
      chk("reset_state", {mem_rd_en, mem_addr, load_weight, pixel_out_r, pixel_out_g, pixel_out_b,
                          pixel_valid, sof, eol, busy, done}, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", {busy, load_weight, mem_rd_en}, 0);

      // T2: cycle-exact frame with pixel_ready high
      pulse_start();
      for (int k = 0; k < 21; k++) begin
         pixel_ready = tbl[k].rdy;
         @(negedge clk);
         chk($sformatf("t2_cyc%0d", k),
             {load_weight, mem_rd_en, pixel_valid, pixel_out_r, sof, eol, done, busy},
             {tbl[k].lw, tbl[k].rd, tbl[k].vld, tbl[k].dat, tbl[k].sf, tbl[k].el, tbl[k].dn, tbl[k].bsy});
         @(posedge clk); #1;
      end
      check_frames("t2", 1);

      // T3: random backpressure
      pulse_start();
      run_until_done("t3", 1'b1, 300);
      check_frames("t3", 1);

      // T4: stall exactly when the read for beat 5 returns
      pulse_start();
      wait_beat("t4", 8'd4);
      @(posedge clk); #1 pixel_ready = 1'b0;
      @(negedge clk);
      chk("t4_land", {pixel_valid, mem_rd_en, pixel_out_r}, {1'b1, 1'b0, 8'd5});
      @(posedge clk); #1 pixel_ready = 1'b1;
      @(negedge clk);
      chk("t4_skid_out", {pixel_valid, mem_rd_en, pixel_out_r}, {1'b1, 1'b1, 8'd5});
      @(negedge clk);
      chk("t4_next", {pixel_valid, pixel_out_r}, {1'b1, 8'd6});
      run_until_done("t4", 1'b0, 40);
      check_frames("t4", 1);

      // T1: async reset mid-STREAM, then rerun
      pulse_start();
      wait_beat("t1", 8'd5);
      @(posedge clk); #2 rst = 1'b0;
      #1;
      chk("t1_rst_outputs", {mem_rd_en, mem_addr, load_weight, pixel_out_r, pixel_out_g, pixel_out_b,
                             pixel_valid, sof, eol, busy, done}, 0);
      d0 = done_cnt;
      @(posedge clk); #1 rst = 1'b1;
      beats.delete();
      repeat (3) @(posedge clk);
      #1;
      chk("t1_no_done", {busy, 32'(done_cnt)}, {1'b0, 32'(d0)});
      pulse_start();
      run_until_done("t1_rerun", 1'b0, 40);
      check_frames("t1_rerun", 1);

      // T5a: start held high across two frames
      lw0 = lw_cnt; d0 = done_cnt; nd = 0; cyc = 0; chk_idle = 1'b0;
      @(posedge clk); #1 start = 1'b1;
      while (nd < 2 && cyc < 120) begin
         @(negedge clk);
         cyc++;
         if (chk_idle) begin
            chk("t5_idle_after_done", busy, 0);
            chk_idle = 1'b0;
         end
         if (done) begin
            nd++;
            chk_idle = 1'b1;
         end
      end
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("t5_idle_final", busy, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("t5a_counts", {32'(lw_cnt - lw0), 32'(done_cnt - d0)}, {32'd2, 32'd2});
      check_frames("t5a", 2);

      // T5b: start pulsed during STREAM is ignored
      lw0 = lw_cnt; d0 = done_cnt;
      pulse_start();
      wait_beat("t5b", 8'd2);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      run_until_done("t5b", 1'b0, 40);
      repeat (4) @(posedge clk);
      #1;
      chk("t5b_counts", {busy, 32'(lw_cnt - lw0), 32'(done_cnt - d0)}, {1'b0, 32'd1, 32'd1});
      check_frames("t5b", 1);

      // T6: full 224x224 frame
      @(posedge clk); #1 start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      cyc = 0;
      while (dc2 == 0 && cyc < 51000) begin
         @(negedge clk);
         cyc++;
      end
      chk("t6_done_seen", (dc2 != 0), 1);
      repeat (3) @(posedge clk);
      #1;
      chk("t6_beats", beats2, 50176);
      chk("t6_data_err", err2, 0);
      chk("t6_eol_cnt", eolc2, 224);
      chk("t6_pulses", {32'(sofc2), 32'(lwc2), 32'(dc2)}, {32'd1, 32'd1, 32'd1});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
